// File: rtl/csel_adder_pipe_if.sv
// Operand/result handshake bundle for csel_adder_pipe.
// The producer/consumer side uses master; the adder uses slave.
interface csel_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/csel_adder_pipe.sv
// Two-stage carry-select adder/subtractor. S1 precomputes every block sum for
// both carry-ins; S2 ripples the block select chain and registers the result.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input logic              clk,
  input logic              rst,
  csel_adder_pipe_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;

  if (WIDTH < 2) begin : g_badWidth
    $error("csel_adder_pipe: WIDTH must be at least 2");
  end
  if ((WIDTH % BLK) != 0) begin : g_badBlk
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK");
  end

  logic                      w_s2Load;
  logic                      w_s1Load;
  logic [WIDTH-1:0]          w_bEff;
  logic                      w_c0;
  logic [NBLK-1:0][BLK-1:0]  w_sum0;
  logic [NBLK-1:0][BLK-1:0]  w_sum1;
  logic [NBLK-1:0]           w_co0;
  logic [NBLK-1:0]           w_co1;
  logic                      w_cm0;
  logic                      w_cm1;

  logic                      r_s1Valid;
  logic [NBLK-1:0][BLK-1:0]  r_s1Sum0;
  logic [NBLK-1:0][BLK-1:0]  r_s1Sum1;
  logic [NBLK-1:0]           r_s1Co0;
  logic [NBLK-1:0]           r_s1Co1;
  logic                      r_s1Cm0;
  logic                      r_s1Cm1;
  logic                      r_s1C0;

  logic [NBLK:0]             w_carry;
  logic [WIDTH-1:0]          w_sum;
  logic                      w_cMsb;

  logic                      r_s2Valid;
  logic [WIDTH-1:0]          r_sum;
  logic                      r_cout;
  logic                      r_ovf;
  logic                      r_zero;

  assign w_s2Load     = !r_s2Valid || bus.out_ready;
  assign w_s1Load     = !r_s1Valid || w_s2Load;
  assign bus.in_ready = w_s1Load;

  // Carry into the MSB falls out of sum ^ a ^ b at that bit, which also covers BLK = 1.
  always_comb begin
    w_bEff = bus.sub ? ~bus.b : bus.b;
    w_c0   = bus.sub | bus.cin;
    w_sum0 = '0;
    w_sum1 = '0;
    w_co0  = '0;
    w_co1  = '0;
    for (int i = 0; i < NBLK; i++) begin
      {w_co0[i], w_sum0[i]} = {1'b0, bus.a[i*BLK +: BLK]} + {1'b0, w_bEff[i*BLK +: BLK]};
      {w_co1[i], w_sum1[i]} = {1'b0, bus.a[i*BLK +: BLK]} + {1'b0, w_bEff[i*BLK +: BLK]}
                              + {{BLK{1'b0}}, 1'b1};
    end
    w_cm0 = w_sum0[NBLK-1][BLK-1] ^ bus.a[WIDTH-1] ^ w_bEff[WIDTH-1];
    w_cm1 = w_sum1[NBLK-1][BLK-1] ^ bus.a[WIDTH-1] ^ w_bEff[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Sum0  <= '0;
      r_s1Sum1  <= '0;
      r_s1Co0   <= '0;
      r_s1Co1   <= '0;
      r_s1Cm0   <= 1'b0;
      r_s1Cm1   <= 1'b0;
      r_s1C0    <= 1'b0;
    end else if (w_s1Load) begin
      r_s1Valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1Sum0 <= w_sum0;
        r_s1Sum1 <= w_sum1;
        r_s1Co0  <= w_co0;
        r_s1Co1  <= w_co1;
        r_s1Cm0  <= w_cm0;
        r_s1Cm1  <= w_cm1;
        r_s1C0   <= w_c0;
      end
    end
  end

  always_comb begin
    w_carry    = '0;
    w_carry[0] = r_s1C0;
    w_sum      = '0;
    for (int i = 0; i < NBLK; i++) begin
      w_sum[i*BLK +: BLK] = w_carry[i] ? r_s1Sum1[i] : r_s1Sum0[i];
      w_carry[i+1]        = w_carry[i] ? r_s1Co1[i]  : r_s1Co0[i];
    end
    w_cMsb = w_carry[NBLK-1] ? r_s1Cm1 : r_s1Cm0;
  end

  // Bubbles advance the valid bit only, so held results survive idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[NBLK];
        r_ovf  <= w_cMsb ^ w_carry[NBLK];
        r_zero <= (w_sum == '0);
      end
    end
  end

  assign bus.out_valid = r_s2Valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed bench for csel_adder_pipe (WIDTH=16, BLK=4) plus a randomised
// block-size sweep on extra instances with BLK = 1, 2, 8, 16.
module tb_csel_adder_pipe;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  csel_adder_pipe_if #(.WIDTH(16)) bus ();

  csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0]       swInValid, swInReady, swCin, swSub;
  logic [3:0]       swOutValid, swOutReady, swCout, swOvf, swZero;
  logic [3:0][15:0] swA, swB, swSum;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW_BLK = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    csel_adder_pipe_if #(.WIDTH(16)) swIf ();
    csel_adder_pipe #(.WIDTH(16), .BLK(SW_BLK)) swDut (
      .clk (clk),
      .rst (rst),
      .bus (swIf)
    );
    assign swIf.in_valid  = swInValid[g];
    assign swIf.a         = swA[g];
    assign swIf.b         = swB[g];
    assign swIf.cin       = swCin[g];
    assign swIf.sub       = swSub[g];
    assign swIf.out_ready = swOutReady[g];
    assign swInReady[g]   = swIf.in_ready;
    assign swOutValid[g]  = swIf.out_valid;
    assign swSum[g]       = swIf.sum;
    assign swCout[g]      = swIf.cout;
    assign swOvf[g]       = swIf.ovf;
    assign swZero[g]      = swIf.zero;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setOp(input logic [15:0] opA, input logic [15:0] opB,
                       input logic opCin, input logic opSub);
    bus.a        = opA;
    bus.b        = opB;
    bus.cin      = opCin;
    bus.sub      = opSub;
    bus.in_valid = 1'b1;
  endtask

  // Presents one operand set for exactly one edge, then withdraws it.
  task automatic issueOp(input logic [15:0] opA, input logic [15:0] opB,
                         input logic opCin, input logic opSub);
    setOp(opA, opB, opCin, opSub);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    if ({bus.cout, bus.ovf, bus.zero, bus.sum} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 00000",
               {bus.cout, bus.ovf, bus.zero, bus.sum});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  // Each vector: {a, b, cin, sub, expected {cout, ovf, zero, sum}}.
  task automatic test_add_sub();
    logic [15:0] va  [5];
    logic [15:0] vb  [5];
    logic        vc  [5];
    logic        vs  [5];
    logic [18:0] ve  [5];
    va = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    vb = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ve = '{{3'b000, 16'h0100}, {3'b101, 16'h0000}, {3'b010, 16'h8000},
           {3'b000, 16'hFFFE}, {3'b110, 16'h7FFF}};
    for (int i = 0; i < 5; i++) begin
      issueOp(va[i], vb[i], vc[i], vs[i]);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL arith_early_%0d: out_valid got %b, expected 0", i, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum} !== {1'b1, ve[i]}) begin
        errors++;
        $display("[TB] FAIL arith_%0d: got valid=%b flags(c,o,z)=%b%b%b sum=%h, expected valid=1 %b sum=%h",
                 i, bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum, ve[i][18:16], ve[i][15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vc [4];
    logic        vs [4];
    logic [18:0] ve [4];
    va = '{16'h0F0F, 16'hAAAA, 16'h1234, 16'h0000};
    vb = '{16'h00F1, 16'h5555, 16'h0234, 16'h0000};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b1, 1'b0};
    ve = '{{3'b000, 16'h1000}, {3'b000, 16'hFFFF}, {3'b100, 16'h1000}, {3'b000, 16'h0001}};
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) setOp(va[i], vb[i], vc[i], vs[i]);
      else       bus.in_valid = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum} !== {1'b1, ve[i-2]}) begin
          errors++;
          $display("[TB] FAIL b2b_%0d: got valid=%b %b%b%b sum=%h, expected valid=1 %b sum=%h",
                   i - 2, bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum,
                   ve[i-2][18:16], ve[i-2][15:0]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_pressure();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    setOp(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_empty: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    setOp(16'h0002, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_half: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    setOp(16'h0003, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_ready_full_%0d: got %b, expected 0", i, bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, bus.sum} !== {1'b1, 16'h0002}) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b sum=%h, expected valid=1 sum=0002",
                 i, bus.out_valid, bus.sum);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b, expected 1", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.sum} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("[TB] FAIL bp_out_0: got valid=%b sum=%h, expected valid=1 sum=0002",
               bus.out_valid, bus.sum);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum} !== {1'b1, 16'h0004}) begin
      errors++;
      $display("[TB] FAIL bp_out_1: got valid=%b sum=%h, expected valid=1 sum=0004",
               bus.out_valid, bus.sum);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum} !== {1'b1, 16'h0006}) begin
      errors++;
      $display("[TB] FAIL bp_out_2: got valid=%b sum=%h, expected valid=1 sum=0006",
               bus.out_valid, bus.sum);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_no_dup: out_valid got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_flight();
    logic sawStale;
    sawStale = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    setOp(16'h0010, 16'h0020, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    setOp(16'h0100, 16'h0200, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.sum} !== {1'b1, 16'h0030}) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got valid=%b sum=%h, expected valid=1 sum=0030",
               bus.out_valid, bus.sum);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_clear: got valid=%b %b%b%b sum=%h, expected all 0",
               bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.sum);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) sawStale = 1'b1;
    end
    checks++;
    if (sawStale !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_stale: stale result seen=%b, expected 0", sawStale);
    end
    issueOp(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_early: out_valid got %b, expected 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum} !== {1'b1, 16'h2345}) begin
      errors++;
      $display("[TB] FAIL rstmid_after: got valid=%b sum=%h, expected valid=1 sum=2345",
               bus.out_valid, bus.sum);
    end
  endtask

  task automatic test_sweep(input int k);
    logic [18:0] expQ[$];
    logic [18:0] e;
    logic [18:0] obs;
    logic [15:0] bEff;
    logic [15:0] s;
    logic [16:0] full;
    logic        c0;
    logic        accepted;
    int          sent;
    int          got;
    int          cycles;
    sent     = 0;
    got      = 0;
    cycles   = 0;
    accepted = 1'b1;
    swInValid[k] = 1'b0;
    while (got < 1000 && cycles < 20000) begin
      @(posedge clk);
      #1;
      if (accepted || !swInValid[k]) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          swA[k]       = 16'($urandom);
          swB[k]       = 16'($urandom);
          swCin[k]     = 1'($urandom_range(0, 1));
          swSub[k]     = 1'($urandom_range(0, 1));
          swInValid[k] = 1'b1;
        end else begin
          swInValid[k] = 1'b0;
        end
      end
      swOutReady[k] = (sent >= 1000) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cycles++;
      if (swOutValid[k] && swOutReady[k]) begin
        checks++;
        obs = {swCout[k], swOvf[k], swZero[k], swSum[k]};
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sweep_%0d_extra: got unexpected result %h, expected none", k, obs);
        end else begin
          e = expQ.pop_front();
          got++;
          if (obs !== e) begin
            errors++;
            $display("[TB] FAIL sweep_%0d_op%0d: got %h, expected %h (cout,ovf,zero,sum)",
                     k, got - 1, obs, e);
          end
        end
      end
      accepted = swInValid[k] && swInReady[k];
      if (accepted) begin
        bEff = swSub[k] ? ~swB[k] : swB[k];
        c0   = swSub[k] ? 1'b1 : swCin[k];
        full = {1'b0, swA[k]} + {1'b0, bEff} + {16'h0, c0};
        s    = full[15:0];
        e    = {full[16], (swA[k][15] == bEff[15]) && (s[15] != swA[k][15]), (s == 16'h0), s};
        expQ.push_back(e);
        sent++;
      end
    end
    swInValid[k] = 1'b0;
    checks++;
    if (got != 1000) begin
      errors++;
      $display("[TB] FAIL sweep_%0d_count: got %0d results, expected 1000", k, got);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    swInValid  = '0;
    swOutReady = '1;
    swCin      = '0;
    swSub      = '0;
    swA        = '0;
    swB        = '0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_flight();
    for (int k = 0; k < 4; k++) test_sweep(k);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
